// File: rtl/pc_ir_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_ir_datapath_pkg
// Purpose  : Opcodes and select encodings shared by the datapath and control.
// Revision : 1.0 - initial release
// ============================================================================
package pc_ir_datapath_pkg;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] J      = 6'b000010;
    localparam logic [5:0] END    = 6'b111111;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10,
        PCS_HOLD   = 2'b11
    } pc_src_e;

    typedef enum logic {
        IOD_PC     = 1'b0,
        IOD_ALUOUT = 1'b1
    } iord_e;

endpackage
`default_nettype wire

// File: rtl/pc_ir_datapath_instr_fields.sv
`default_nettype none
// ============================================================================
// Module   : pc_ir_datapath_instr_fields
// Purpose  : Combinational IR field splitter and immediate extender.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ir_datapath_instr_fields #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] instr,
    output logic [5:0]        op_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm_sext,
    output logic [DATA_W-1:0] imm_shl2
);

    assign op_code  = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_sext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign imm_shl2 = {imm_sext[DATA_W-3:0], 2'b00};

endmodule
`default_nettype wire

// File: rtl/pc_ir_datapath.sv
`default_nettype none
// ============================================================================
// Module   : pc_ir_datapath
// Purpose  : PC / IR / MDR / ALUOut registers of the multi-cycle datapath.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ir_datapath
    import pc_ir_datapath_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write,
    input  logic              pc_write_cond,
    input  logic [1:0]        pc_source,
    input  logic              ir_write,
    input  logic              i_or_d,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        op_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm_sext,
    output logic [DATA_W-1:0] imm_shl2,
    output logic [DATA_W-1:0] alu_out,
    output logic [CNT_W-1:0]  instr_count,
    output logic [DATA_W-1:0] mdr,
    output logic              halted
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_mdr;
    logic [CNT_W-1:0]  r_count;
    logic              r_halted;

    logic              w_pc_en;
    logic              w_ir_load;
    logic [DATA_W-1:0] w_next_pc;

    // Once halted, control requests are ignored so PC, IR and the count freeze.
    assign w_pc_en   = (pc_write | (pc_write_cond & alu_zero)) & ~r_halted;
    assign w_ir_load = ir_write & ~r_halted;

    always_comb begin
        w_next_pc = r_pc;
        case (pc_src_e'(pc_source))
            PCS_ALU:    w_next_pc = alu_result;
            PCS_ALUOUT: w_next_pc = r_alu_out;
            PCS_JUMP:   w_next_pc = {r_pc[DATA_W-1:28], r_instr[25:0], 2'b00};
            default:    w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= PC_RESET;
            r_instr   <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
            r_count   <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_alu_out <= alu_result;
            r_mdr     <= mem_rdata;
            if (w_pc_en) begin
                r_pc <= w_next_pc;
            end
            if (w_ir_load) begin
                r_instr <= mem_rdata;
                if (!(&r_count)) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            // Halt is recognised one edge after END lands in the IR.
            if (op_code == END) begin
                r_halted <= 1'b1;
            end
        end
    end

    pc_ir_datapath_instr_fields #(
        .DATA_W (DATA_W)
    ) u_instr_fields (
        .instr    (r_instr),
        .op_code  (op_code),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .funct    (funct),
        .imm_sext (imm_sext),
        .imm_shl2 (imm_shl2)
    );

    assign mem_addr    = (iord_e'(i_or_d) == IOD_ALUOUT) ? r_alu_out : r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign alu_out     = r_alu_out;
    assign mdr         = r_mdr;
    assign instr_count = r_count;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_ir_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_ir_datapath
// Purpose  : Scoreboard bench for pc_ir_datapath against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pc_ir_datapath;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        ir_write;
    logic        i_or_d;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op_code;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_shl2;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [15:0] instr_count;
    logic        halted;

    pc_ir_datapath dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .pc            (pc),
        .instr         (instr),
        .op_code       (op_code),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .funct         (funct),
        .imm_sext      (imm_sext),
        .imm_shl2      (imm_shl2),
        .alu_out       (alu_out),
        .mdr           (mdr),
        .instr_count   (instr_count),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_out;
        logic [31:0] mdr;
        logic [31:0] mem_addr;
        int          cnt;
        bit          halted;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Architectural model state
    logic [31:0] m_pc, m_ir, m_aluout, m_mdr;
    int          m_cnt;
    bit          m_halt;

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_aluout = 32'h0; m_mdr = 32'h0;
        m_cnt = 0; m_halt = 0;
    endtask

    task automatic model_edge(input logic pw, input logic pwc, input logic [1:0] ps,
                              input logic irw, input logic [31:0] ar,
                              input logic az, input logic [31:0] rdat);
        logic [31:0] npc, nir;
        bit          halt_n;
        npc    = m_pc;
        nir    = m_ir;
        halt_n = m_halt || ((m_ir >> 26) == 32'd63);
        if (!m_halt && (pw || (pwc && az))) begin
            if (ps == 2'd0)      npc = ar;
            else if (ps == 2'd1) npc = m_aluout;
            else if (ps == 2'd2) npc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
        end
        if (!m_halt && irw) begin
            nir = rdat;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        m_pc = npc; m_ir = nir; m_aluout = ar; m_mdr = rdat; m_halt = halt_n;
    endtask

    task automatic push_exp(input logic iod);
        exp_t e;
        e.pc = m_pc; e.instr = m_ir; e.alu_out = m_aluout; e.mdr = m_mdr;
        e.mem_addr = iod ? m_aluout : m_pc;
        e.cnt = m_cnt; e.halted = m_halt;
        q.push_back(e);
    endtask

    // Called at posedge+1: drive, record expectation of the current state, then clock.
    task automatic step(input logic pw, input logic pwc, input logic [1:0] ps,
                        input logic irw, input logic iod, input logic [31:0] ar,
                        input logic az, input logic [31:0] rdat);
        pc_write = pw; pc_write_cond = pwc; pc_source = ps; ir_write = irw;
        i_or_d = iod; alu_result = ar; alu_zero = az; mem_rdata = rdat;
        push_exp(iod);
        @(posedge clk);
        model_edge(pw, pwc, ps, irw, ar, az, rdat);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Asynchronous reset raised between edges; checked before any clock edge.
    task automatic reset_pulse();
        pc_write = 0; pc_write_cond = 0; pc_source = 2'd3; ir_write = 0;
        i_or_d = 0; alu_result = 32'h0; alu_zero = 0; mem_rdata = 32'h0;
        reset = 1'b1;
        model_reset();
        push_exp(1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 2'd3, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            vectors++;
            chk("pc",       pc,       mon_e.pc);
            chk("instr",    instr,    mon_e.instr);
            chk("alu_out",  alu_out,  mon_e.alu_out);
            chk("mdr",      mdr,      mon_e.mdr);
            chk("mem_addr", mem_addr, mon_e.mem_addr);
            chk("count",    32'(instr_count), 32'(mon_e.cnt));
            chk("halted",   32'(halted),      32'(mon_e.halted));
            chk("op_code",  32'(op_code),     mon_e.instr >> 26);
            chk("rs",       32'(rs),          (mon_e.instr >> 21) & 32'd31);
            chk("rt",       32'(rt),          (mon_e.instr >> 16) & 32'd31);
            chk("rd",       32'(rd),          (mon_e.instr >> 11) & 32'd31);
            chk("funct",    32'(funct),       mon_e.instr & 32'd63);
            chk("imm_sext", imm_sext, 32'($signed(mon_e.instr[15:0])));
            chk("imm_shl2", imm_shl2, 32'($signed(mon_e.instr[15:0])) * 4);
        end
    end

    initial begin
        logic [31:0] r;
        reset = 1'b1;
        pc_write = 0; pc_write_cond = 0; pc_source = 2'd3; ir_write = 0;
        i_or_d = 0; alu_result = 32'h0; alu_zero = 0; mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        reset_pulse();

        // Fetch and increment
        step(0, 0, 2'd0, 1, 0, 32'h0,  0, 32'h2008_0005);
        step(1, 0, 2'd0, 0, 0, 32'h4,  0, 32'h0);
        idle();
        // Branch taken / not taken on alu_zero
        step(0, 0, 2'd3, 0, 1, 32'h40, 0, 32'h0);
        step(0, 1, 2'd1, 0, 1, 32'h40, 1, 32'h0);
        step(0, 0, 2'd3, 0, 0, 32'h80, 0, 32'h0);
        step(0, 1, 2'd1, 0, 1, 32'h0,  0, 32'h0);
        idle();
        // Jump keeps the upper PC nibble
        step(1, 0, 2'd0, 0, 0, 32'h1000_0008, 0, 32'h0);
        step(0, 0, 2'd3, 1, 0, 32'h0, 0, 32'h0800_0010);
        step(1, 0, 2'd2, 0, 0, 32'h0, 0, 32'h0);
        idle();
        // Negative immediate, then hold select ignores pc_write
        step(0, 0, 2'd3, 1, 0, 32'h0, 0, 32'h2008_FFFC);
        step(1, 0, 2'd3, 0, 0, 32'h1234, 0, 32'h0);
        idle();
        // Halt, frozen state, reset mid-run
        step(0, 0, 2'd3, 1, 0, 32'h0, 0, 32'hFC00_0000);
        step(1, 0, 2'd0, 1, 0, 32'h99, 0, 32'h1111_2222);
        step(1, 0, 2'd0, 1, 1, 32'h55, 1, 32'h3333_4444);
        step(0, 1, 2'd1, 1, 0, 32'h66, 1, 32'h5555_6666);
        idle();
        reset_pulse();
        idle();

        // Randomised traffic with occasional END and async resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 150) == 0) begin
                reset_pulse();
            end else begin
                r = $urandom;
                if ($urandom_range(0, 80) == 0) r[31:26] = 6'h3F;
                else if (r[31:26] == 6'h3F) r[31:26] = 6'h00;
                step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
                     2'($urandom_range(0, 3)), logic'($urandom_range(0, 2) == 0),
                     logic'($urandom_range(0, 1)), $urandom, logic'($urandom_range(0, 1)), r);
            end
        end

        // Counter saturation
        reset_pulse();
        for (int i = 0; i < 65540; i++) begin
            r = $urandom & 32'h03FF_FFFF;
            step(0, 0, 2'd3, 1, 0, 32'h0, 0, r);
        end
        idle();

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
